// File: rtl/fft_bitrev_reorder_if.sv
// Streaming handshake bundle for the FFT bit-reversal reorder stage.
// slave = reorder block side, master = upstream/downstream environment side.
interface fft_bitrev_reorder_if #(
    parameter int W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                out_last;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer turning bit-reversed R2SDF output into natural order.
// Optional macro FFT_REORDER_OVF_EN adds a sticky in_overflow flag for dropped input samples.
module fft_bitrev_reorder #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef FFT_REORDER_OVF_EN
    output logic in_overflow,
`endif
    fft_bitrev_reorder_if.slave bus
);
    localparam int L = 1 << N;
    localparam logic [N-1:0] LAST = {N{1'b1}};

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = a[N-1-i];
        return r;
    endfunction

    logic [2*W-1:0] mem [0:2*L-1];

    logic [N-1:0] wr_cnt;
    logic [N-1:0] rd_cnt;
    logic         wr_bank;
    logic         rd_bank;
    logic [1:0]   full;

    logic                acc_p0;
    logic                load_p0;
    logic [1:0]          set_mask;
    logic [1:0]          clr_mask;
    logic [2*W-1:0]      rd_word;

    logic                vld_p1;
    logic                last_p1;
    logic signed [W-1:0] re_p1;
    logic signed [W-1:0] im_p1;

    assign bus.in_ready = ~full[wr_bank];
    assign acc_p0       = bus.in_valid & ~full[wr_bank];
    assign load_p0      = full[rd_bank] & (~vld_p1 | bus.out_ready);
    assign rd_word      = mem[{rd_bank, rd_cnt}];

    // Bank hand-over: writer completes one bank while the reader drains the other.
    always_comb begin
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (acc_p0 && wr_cnt == LAST) set_mask[wr_bank] = 1'b1;
        if (load_p0 && rd_cnt == LAST) clr_mask[rd_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (acc_p0) mem[{wr_bank, bitrev(wr_cnt)}] <= {bus.in_re, bus.in_im};
    end

    // p0 -> p1: bank read into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= 2'b00;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            re_p1   <= '0;
            im_p1   <= '0;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
            if (acc_p0) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LAST) wr_bank <= ~wr_bank;
            end
            if (load_p0) begin
                re_p1   <= rd_word[2*W-1:W];
                im_p1   <= rd_word[W-1:0];
                last_p1 <= (rd_cnt == LAST);
                vld_p1  <= 1'b1;
                rd_cnt  <= rd_cnt + 1'b1;
                if (rd_cnt == LAST) rd_bank <= ~rd_bank;
            end else if (bus.out_ready && vld_p1) begin
                vld_p1 <= 1'b0;
            end
        end
    end

`ifdef FFT_REORDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) in_overflow <= 1'b0;
        else if (bus.in_valid && full[wr_bank]) in_overflow <= 1'b1;
    end
`endif

    assign bus.out_valid = vld_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_re    = re_p1;
    assign bus.out_im    = im_p1;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: vector table, directed corner sequences
// and randomized streaming against a frame-level reference model.
module tb_fft_bitrev_reorder;
    localparam int N = 3;
    localparam int W = 16;
    localparam int L = 1 << N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.W(W)) bus ();
`ifdef FFT_REORDER_OVF_EN
    logic in_overflow;
`endif

    fft_bitrev_reorder #(.N(N), .W(W)) dut (
        .clk(clk),
        .rst(rst),
`ifdef FFT_REORDER_OVF_EN
        .in_overflow(in_overflow),
`endif
        .bus(bus)
    );

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic                last;
    } samp_t;

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic signed [W-1:0] exp_re;
        logic signed [W-1:0] exp_im;
        logic                exp_last;
    } vec_t;

    int checks = 0;
    int errors = 0;

    samp_t               exp_q[$];
    logic signed [W-1:0] frm_re[L];
    logic signed [W-1:0] frm_im[L];
    int                  fill;
    logic                acc;
    int                  cyc, first_c, last_c, n_out;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Natural index j holds the sample that arrived j-th in bit-reversed order.
    function automatic int brev(input int k);
        int r = 0;
        int v = k;
        for (int i = 0; i < N; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        fill = 0;
        first_c = -1;
        last_c = -1;
        n_out = 0;
    endtask

    // Inputs are already set at a negedge; observe this cycle's handshakes, advance to next negedge.
    task automatic step();
        samp_t e;
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            frm_re[fill] = bus.in_re;
            frm_im[fill] = bus.in_im;
            fill++;
            if (fill == L) begin
                for (int j = 0; j < L; j++) begin
                    e.re = frm_re[brev(j)];
                    e.im = frm_im[brev(j)];
                    e.last = (j == L - 1);
                    exp_q.push_back(e);
                end
                fill = 0;
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_re", bus.out_re, e.re);
                chk("out_im", bus.out_im, e.im);
                chk("out_last", bus.out_last, e.last);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 200) begin
            step();
            guard++;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_idle", bus.out_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
    endtask

    vec_t tv[L];
    int   perm[L] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   sent;
    int   guard;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_re = '0;
        bus.in_im = '0;
        cyc = 0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_re", bus.out_re, 0);
        chk("reset_out_im", bus.out_im, 0);
        chk("reset_out_last", bus.out_last, 0);
`ifdef FFT_REORDER_OVF_EN
        chk("reset_overflow", in_overflow, 0);
`endif
        @(negedge clk);

        // Test 1: vector table, one frame with exact latency
        for (int k = 0; k < L; k++) begin
            tv[k].re = W'(k);
            tv[k].im = W'(-k);
            tv[k].exp_re = W'(perm[k]);
            tv[k].exp_im = W'(-perm[k]);
            tv[k].exp_last = (k == L - 1);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < L; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re = tv[k].re;
            bus.in_im = tv[k].im;
            #1;
            chk("t1_in_ready", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("t1_lat_early", bus.out_valid, 0);
        @(negedge clk);
        for (int k = 0; k < L; k++) begin
            chk("t1_valid", bus.out_valid, 1);
            chk("t1_re", bus.out_re, tv[k].exp_re);
            chk("t1_im", bus.out_im, tv[k].exp_im);
            chk("t1_last", bus.out_last, tv[k].exp_last);
            @(negedge clk);
        end
        chk("t1_valid_end", bus.out_valid, 0);

        // Test 2: four back-to-back frames, gapless output
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4 * L; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re = W'(k * 3 + 1);
            bus.in_im = W'(-k * 5);
            step();
            chk("t2_accept", acc, 1);
        end
        drain();
        chk("t2_count", n_out, 4 * L);
        chk("t2_gapless", last_c - first_c + 1, 4 * L);

        // Test 3: backpressure with three frames offered
        do_reset();
        sent = 0;
        guard = 0;
        while (sent < 2 * L && guard < 100) begin
            bus.in_valid = 1'b1;
            bus.in_re = W'(sent);
            bus.in_im = W'(100 + sent);
            step();
            if (acc) sent++;
            guard++;
        end
        chk("t3_sent16", sent, 2 * L);
        chk("t3_in_ready_low", bus.in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re = W'(sent);
            bus.in_im = W'(100 + sent);
            step();
            chk("t3_blocked", acc, 0);
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_re", bus.out_re, 0);
        end
`ifdef FFT_REORDER_OVF_EN
        chk("t3_overflow", in_overflow, 1);
`endif
        bus.out_ready = 1'b1;
        guard = 0;
        while (sent < 3 * L && guard < 100) begin
            bus.in_valid = 1'b1;
            bus.in_re = W'(sent);
            bus.in_im = W'(100 + sent);
            step();
            if (acc) sent++;
            guard++;
        end
        chk("t3_sent24", sent, 3 * L);
        drain();
        chk("t3_count", n_out, 3 * L);
`ifdef FFT_REORDER_OVF_EN
        chk("t3_overflow_sticky", in_overflow, 1);
`endif

        // Test 4: reset with one full frame and a partial frame buffered
        do_reset();
        for (int k = 0; k < L + 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re = W'(1000 + k);
            bus.in_im = W'(2000 + k);
            step();
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        chk("t4_out_valid", bus.out_valid, 0);
        chk("t4_in_ready", bus.in_ready, 1);
`ifdef FFT_REORDER_OVF_EN
        chk("t4_overflow_cleared", in_overflow, 0);
`endif
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int k = 0; k < L; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re = W'(-300 - k);
            bus.in_im = W'(400 + 7 * k);
            step();
        end
        drain();
        chk("t4_count", n_out, L);

        // Test 5: full-scale extremes pass bit-exact
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < L; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re = (k == 1) ? -16'sd32768 : (k == 6) ? 16'sd32767 : W'(k);
            bus.in_im = (k == 1) ? 16'sd32767 : (k == 6) ? -16'sd32768 : W'(-k);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        step();
        step();
        chk("t5_pos4_re", bus.out_re, -32768);
        chk("t5_pos4_im", bus.out_im, 32767);
        drain();

        // Random traffic with random stalls on both sides
        do_reset();
        sent = 0;
        guard = 0;
        while (sent < 10 * L && guard < 3000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_re = W'($urandom);
            bus.in_im = W'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
            if (acc) sent++;
            guard++;
        end
        chk("rand_sent", sent, 10 * L);
        drain();
        chk("rand_count", n_out, 10 * L);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
